// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: one digit per slot, per-frame input snapshot,
// anti-ghost blanking at slot start, per-digit enable and leading-zero suppression.
module seg7_scan #(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     en,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   lzs,
  output logic [6:0]             seg,
  output logic                   dp_n,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIGITS - 1);

  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [4*NDIGITS-1:0]   r_val;
  logic [NDIGITS-1:0]     r_en;
  logic [NDIGITS-1:0]     r_dp;
  logic                   r_lzs;

  logic                   w_fs;
  logic [3:0]             w_nib;
  logic [NDIGITS-1:0]     w_sup;
  logic                   w_run;
  logic                   w_blank;
  logic [NDIGITS-1:0]     w_onehot;
  logic [6:0]             w_seg;
  logic                   w_dp_n;
  logic [NDIGITS-1:0]     w_an;

  // Hex nibble to active-low g..a pattern.
  function automatic logic [6:0] seg_dec(input logic [3:0] n);
    case (n)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  endfunction

  assign w_fs = (r_cnt == '0) && (r_idx == '0);

  // Slot counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Per-frame snapshot of the display inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_val <= '0;
      r_en  <= '0;
      r_dp  <= '0;
      r_lzs <= 1'b0;
    end else if (w_fs) begin
      r_val <= value;
      r_en  <= en;
      r_dp  <= dp;
      r_lzs <= lzs;
    end
  end

  // Leading-zero run from the top digit; a disabled digit reads as zero, digit 0 is always kept.
  always_comb begin
    w_sup = '0;
    w_run = r_lzs;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      w_run    = w_run && (!r_en[i] || (r_val[4*i +: 4] == 4'h0));
      w_sup[i] = w_run;
    end
  end

  assign w_nib    = r_val[4*r_idx +: 4];
  assign w_blank  = !r_en[r_idx] || w_sup[r_idx];
  assign w_onehot = NDIGITS'(1) << r_idx;

  // Next display state from current slot position and snapshot.
  always_comb begin
    w_seg  = 7'h7F;
    w_dp_n = 1'b1;
    w_an   = {NDIGITS{1'b1}};
    if ((r_cnt >= BLANK) && !w_blank) begin
      w_seg  = seg_dec(w_nib);
      w_dp_n = ~r_dp[r_idx];
      w_an   = ~w_onehot;
    end else begin
      w_seg  = 7'h7F;
      w_dp_n = 1'b1;
      w_an   = {NDIGITS{1'b1}};
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg   <= 7'h7F;
      dp_n  <= 1'b1;
      an    <= {NDIGITS{1'b1}};
      frame <= 1'b0;
    end else begin
      seg   <= w_seg;
      dp_n  <= w_dp_n;
      an    <= w_an;
      frame <= w_fs;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with NDIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
module tb_seg7_scan;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  en;
  logic [3:0]  dp;
  logic        lzs;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame;

  int errors = 0;
  int checks = 0;

  seg7_scan #(.NDIGITS(4), .REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .reset(reset), .value(value), .en(en), .dp(dp), .lzs(lzs),
    .seg(seg), .dp_n(dp_n), .an(an), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, pulse reset and release on a falling edge; the next rising edge is edge 1.
  task automatic start(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d, input logic z);
    reset = 1'b1;
    @(negedge clk);
    value = v; en = e; dp = d; lzs = z;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    start(16'h12AF, 4'hF, 4'b0100, 1'b0);
    checks++;
    if (frame !== 1'b0) begin errors++; $display("FAIL rst_pre_frame: got %b want 0", frame); end
    for (int k = 1; k <= 5; k++) step();
    checks++;
    if (an !== 4'b1110) begin errors++; $display("FAIL rst_lit_before: an=%b want 1110", an); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame !== 1'b0) begin
      errors++; $display("FAIL rst_async: an=%h seg=%h dp_n=%b frame=%b want F 7F 1 0", an, seg, dp_n, frame);
    end
    @(posedge clk); #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame !== 1'b0) begin
      errors++; $display("FAIL rst_held: an=%h seg=%h frame=%b want F 7F 0", an, seg, frame);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      step();
      checks++;
      if (frame !== ((k == 1) || (k == 33) || (k == 65))) begin
        errors++; $display("FAIL frame_period: edge %0d frame=%b", k, frame);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] an_e [4];
    logic [6:0] seg_e [4];
    logic       dpn_e [4];
    int c, s;
    an_e  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_e = '{7'h0E, 7'h08, 7'h24, 7'h79};
    dpn_e = '{1'b1, 1'b1, 1'b0, 1'b1};
    start(16'h12AF, 4'hF, 4'b0100, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step();
      c = (k - 1) % 8;
      s = (k - 1) / 8;
      checks++;
      if (c >= 2) begin
        if (an !== an_e[s] || seg !== seg_e[s] || dp_n !== dpn_e[s]) begin
          errors++; $display("FAIL basic_slot%0d: an=%b seg=%h dp_n=%b want %b %h %b", s, an, seg, dp_n, an_e[s], seg_e[s], dpn_e[s]);
        end
      end else begin
        if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1) begin
          errors++; $display("FAIL basic_blank%0d: an=%b seg=%h dp_n=%b want 1111 7F 1", s, an, seg, dp_n);
        end
      end
    end
  endtask

  task automatic test_blanking();
    int c, zeros;
    start(16'h9876, 4'hF, 4'h0, 1'b0);
    for (int k = 1; k <= 96; k++) begin
      step();
      c = (k - 1) % 8;
      zeros = 0;
      for (int b = 0; b < 4; b++) if (an[b] === 1'b0) zeros++;
      checks++;
      if (zeros > 1) begin errors++; $display("FAIL blank_onehot: edge %0d an=%b", k, an); end
      if (c < 2) begin
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL blank_start: edge %0d an=%b want 1111", k, an); end
      end
    end
  endtask

  task automatic test_lzs();
    logic [15:0] v_t [4];
    logic [3:0]  e_t [4];
    logic        z_t [4];
    logic [3:0]  an_e [4][4];
    logic [6:0]  seg_e [4][4];
    int c, s;
    v_t = '{16'h0040, 16'h0000, 16'h5040, 16'h0040};
    e_t = '{4'hF, 4'hF, 4'b0111, 4'hF};
    z_t = '{1'b1, 1'b1, 1'b1, 1'b0};
    an_e[0] = '{4'b1110, 4'b1101, 4'hF, 4'hF};    seg_e[0] = '{7'h40, 7'h19, 7'h7F, 7'h7F};
    an_e[1] = '{4'b1110, 4'hF, 4'hF, 4'hF};       seg_e[1] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    an_e[2] = '{4'b1110, 4'b1101, 4'hF, 4'hF};    seg_e[2] = '{7'h40, 7'h19, 7'h7F, 7'h7F};
    an_e[3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111}; seg_e[3] = '{7'h40, 7'h19, 7'h40, 7'h40};
    for (int t = 0; t < 4; t++) begin
      start(v_t[t], e_t[t], 4'h0, z_t[t]);
      for (int k = 1; k <= 32; k++) begin
        step();
        c = (k - 1) % 8;
        s = (k - 1) / 8;
        if (c >= 2) begin
          checks++;
          if (an !== an_e[t][s] || seg !== seg_e[t][s] || dp_n !== 1'b1) begin
            errors++; $display("FAIL lzs_case%0d_slot%0d: an=%b seg=%h dp_n=%b want %b %h 1", t, s, an, seg, dp_n, an_e[t][s], seg_e[t][s]);
          end
        end
      end
    end
  endtask

  task automatic test_snapshot();
    int c, s;
    logic [6:0] seg_x;
    start(16'h1111, 4'hF, 4'h0, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k == 12) value = 16'h2222;
      c = (k - 1) % 8;
      s = ((k - 1) / 8) % 4;
      seg_x = (k <= 32) ? 7'h79 : 7'h24;
      if (c >= 2) begin
        checks++;
        if (an !== ~(4'b0001 << s) || seg !== seg_x) begin
          errors++; $display("FAIL snapshot: edge %0d an=%b seg=%h want %b %h", k, an, seg, ~(4'b0001 << s), seg_x);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] an_e [4];
    logic [6:0] seg_e [4];
    logic       dpn_e [4];
    int c, s;
    an_e  = '{4'hF, 4'b1101, 4'hF, 4'b0111};
    seg_e = '{7'h7F, 7'h00, 7'h7F, 7'h00};
    dpn_e = '{1'b1, 1'b0, 1'b1, 1'b0};
    start(16'h8888, 4'b1010, 4'hF, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step();
      c = (k - 1) % 8;
      s = (k - 1) / 8;
      checks++;
      if (an[0] !== 1'b1 || an[2] !== 1'b1) begin
        errors++; $display("FAIL enable_anode: edge %0d an=%b", k, an);
      end
      if (c >= 2) begin
        checks++;
        if (an !== an_e[s] || seg !== seg_e[s] || dp_n !== dpn_e[s]) begin
          errors++; $display("FAIL enable_slot%0d: an=%b seg=%h dp_n=%b want %b %h %b", s, an, seg, dp_n, an_e[s], seg_e[s], dpn_e[s]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    value = 16'h0000;
    en    = 4'h0;
    dp    = 4'h0;
    lzs   = 1'b0;
    #3;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame !== 1'b0) begin
      errors++; $display("FAIL initial_reset: an=%h seg=%h dp_n=%b frame=%b", an, seg, dp_n, frame);
    end
    test_reset();
    test_basic();
    test_blanking();
    test_lzs();
    test_snapshot();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have exactly one clock, one asynchronous active-high reset and the parameters and ports listed in REQ-002 to REQ-013.
REQ-002 The block SHALL have parameter NDIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000: clk cycles per digit slot; REFRESH_DIV > BLANK_CYC is required.
REQ-004 The block SHALL have parameter BLANK_CYC, default 2: anti-ghost cycles with all anodes off at the start of each slot; BLANK_CYC >= 1 is required.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port value, input, 4*NDIGITS bits: hex nibble per digit; nibble i, bits [4i+3:4i], drives digit i, and digit 0 is least significant.
REQ-008 The block SHALL have port en, input, NDIGITS bits: per-digit enable; 0 blanks that digit.
REQ-009 The block SHALL have port dp, input, NDIGITS bits: per-digit decimal point request, 1 = lit.
REQ-010 The block SHALL have port lzs, input, 1 bit: leading-zero suppression enable.
REQ-011 The block SHALL have port seg, output, 7 bits: active-low segments, seg[0]=a … seg[6]=g.
REQ-012 The block SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-013 The block SHALL have ports an, output, NDIGITS bits: active-low digit anodes; and frame, output, 1 bit: one-cycle pulse at each frame start.

Function
REQ-014 The block SHALL hold a slot counter cnt counting 0..REFRESH_DIV-1 and wrapping to 0.
REQ-015 The block SHALL hold a digit index idx, 0..NDIGITS-1, that advances by 1 on each cnt wrap and wraps from NDIGITS-1 to 0.
REQ-016 A frame start SHALL be the cycle with cnt==0 and idx==0.
REQ-017 In a frame-start cycle, the block SHALL capture value, en, dp and lzs into shadow registers.
REQ-018 All display decoding SHALL use only the shadow registers, so input changes mid-frame never alter the current frame.
REQ-019 frame SHALL be registered and SHALL be 1 for exactly the one cycle following each frame-start cycle.
REQ-020 seg, dp_n and an SHALL be registered, and in each cycle SHALL reflect the cnt, idx and shadow state of the previous cycle.
REQ-021 While cnt < BLANK_CYC, an SHALL be all 1s, seg SHALL be 7'h7F and dp_n SHALL be 1.
REQ-022 While cnt >= BLANK_CYC, an SHALL be all 1s except bit idx, which SHALL be 0 unless digit idx is blanked; a blanked digit SHALL give an all 1s.
REQ-023 Digit idx SHALL be blanked when shadow en[idx]==0 or when leading-zero suppression applies (REQ-024).
REQ-024 With shadow lzs==1, digits from NDIGITS-1 downward whose nibble is 0 SHALL be suppressed up to, but excluding, the first nonzero nibble; digit 0 SHALL never be suppressed; a disabled digit counts as zero for this scan.
REQ-025 For a displayed digit, seg SHALL be decoded from the nibble, as g..a hex, per this table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-026 For a displayed digit, dp_n SHALL be ~dp[idx].
REQ-027 For a blanked digit, seg SHALL be 7'h7F and dp_n SHALL be 1.
REQ-028 At most one an bit SHALL be 0 in any cycle.
REQ-029 One full frame SHALL last NDIGITS*REFRESH_DIV cycles, with frame pulses spaced exactly that many cycles apart.

Reset
REQ-030 While reset=1, regardless of clk, the block SHALL hold cnt=0, idx=0, all shadow registers=0, an all 1s, seg=7'h7F, dp_n=1 and frame=0.
REQ-031 The first cycle after reset deassertion SHALL be a frame start, so the first frame pulse appears one cycle after deassertion.
REQ-032 Reset asserted mid-slot SHALL blank all outputs immediately, with no partial-slot completion.

Verification
REQ-033 For all scenarios, the bench SHALL use NDIGITS=4, REFRESH_DIV=8 and BLANK_CYC=2.
REQ-034 The bench SHALL cover reset behaviour: reset pulse mid-slot -> an=4'hF, seg=7'h7F and frame=0 asynchronously; frame=1 one cycle after release; frames then repeat every 32 cycles.
REQ-035 The bench SHALL cover a basic scan: value=16'h12AF, en=4'hF, dp=4'b0100, lzs=0 -> slot 0 an=4'b1110 seg=7'h0E; slot 1 an=4'b1101 seg=7'h08; slot 2 an=4'b1011 seg=7'h24 dp_n=0; slot 3 an=4'b0111 seg=7'h79.
REQ-036 The bench SHALL cover blanking: the first 2 cycles of every slot show an=4'hF; an never has more than one 0 bit over 3 frames.
REQ-037 The bench SHALL cover leading-zero suppression: value=16'h0040, lzs=1 -> digits 3 and 2 blanked (an stays 4'hF in their slots), digit 1 seg=7'h19, digit 0 seg=7'h40; value=16'h0000 with lzs=1 -> only digit 0 lit, seg=7'h40.
REQ-038 The bench SHALL cover the snapshot rule: changing value from 16'h1111 to 16'h2222 during slot 1 -> slots 1..3 of that frame still show 7'h79; the next frame shows 7'h24.
REQ-039 The bench SHALL cover per-digit enable: en=4'b1010 -> anodes for digits 0 and 2 never go low; seg=7'h7F and dp_n=1 in those slots even with dp=4'hF.
